// File: rtl/cpen391_group5_pio_pkg.sv
// Purpose: shared register-map addresses and pulse FSM states for the output PIO.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpen391_group5_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_OUTSET    = 3'd2;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd3;
  localparam logic [2:0] ADDR_PULSE     = 3'd4;

  typedef enum logic {
    PIO_IDLE    = 1'b0,
    PIO_PULSING = 1'b1
  } pio_state_e;

endpackage

// File: rtl/cpen391_group5_pulse_timer.sv
// Purpose: shared down-counter that times the auto-clearing pulse; flags expiry.
// Latency: expire asserts L+1 cycles after the load cycle; load/cancel take effect next edge.
// Backpressure: none; load (retrigger) and cancel both suppress a same-cycle expiry.
module cpen391_group5_pulse_timer
  import cpen391_group5_pio_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 cancel,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 expire
);

  pio_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

  // Expiry fires when the count has run out, unless a write this cycle takes priority.
  always_comb begin
    expire = (state_q == PIO_PULSING) && (cnt_q == '0) && !load && !cancel;
  end

  // Next state: load restarts the count, cancel drops to idle, otherwise count down to expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = PIO_PULSING;
      cnt_d   = len;
    end else if (cancel) begin
      state_d = PIO_IDLE;
      cnt_d   = '0;
    end else if (state_q == PIO_PULSING) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - LEN_WIDTH'(1);
      end else begin
        state_d = PIO_IDLE;
      end
    end
  end

  // State and counter registers; reset drops any pulse in flight without expiring it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PIO_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cpen391_group5_qsys_pio_out.sv
// Purpose: Avalon-MM output PIO with data, atomic set/clear and timed auto-clearing pulse.
// Latency: writes visible on out_port the cycle after the write; readdata registered, 1 cycle.
// Backpressure: none; every access completes in one cycle with no wait states.
module cpen391_group5_qsys_pio_out
  import cpen391_group5_pio_pkg::*;
#(
  parameter int                   WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter int                   LEN_WIDTH   = 16,
  parameter logic [LEN_WIDTH-1:0] LEN_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [31:0]          readdata_q, readdata_d;

  logic                 wr;
  logic                 pulse_load;
  logic                 data_cancel;
  logic                 expire;
  logic [WIDTH-1:0]     wd_data;
  logic [LEN_WIDTH-1:0] wd_len;
  logic [WIDTH-1:0]     data_x;
  logic [WIDTH-1:0]     mask_x;
  logic                 unused_wd;

  assign wr          = chipselect & ~write_n;
  assign wd_data     = writedata[WIDTH-1:0];
  assign wd_len      = writedata[LEN_WIDTH-1:0];
  assign pulse_load  = wr && (address == ADDR_PULSE);
  assign data_cancel = wr && (address == ADDR_DATA);
  // Upper writedata bits are deliberately ignored.
  assign unused_wd   = ^writedata;

  cpen391_group5_pulse_timer #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (pulse_load),
    .cancel (data_cancel),
    .len    (len_q),
    .expire (expire)
  );

  // Register map update: expiry is applied first, then any write overrides it.
  // Applying set/clear on top of the post-expiry view is equivalent to "set/clear,
  // drop those bits from the mask, then clear what remains of the mask".
  always_comb begin
    data_x = expire ? (data_q & ~mask_q) : data_q;
    mask_x = expire ? '0 : mask_q;
    data_d = data_x;
    mask_d = mask_x;
    len_d  = len_q;
    if (wr) begin
      case (address)
        ADDR_DATA: begin
          data_d = wd_data;
          mask_d = '0;
        end
        ADDR_PULSE_LEN: begin
          len_d = wd_len;
        end
        ADDR_OUTSET: begin
          data_d = data_x | wd_data;
          mask_d = mask_x & ~wd_data;
        end
        ADDR_OUTCLEAR: begin
          data_d = data_x & ~wd_data;
          mask_d = mask_x & ~wd_data;
        end
        ADDR_PULSE: begin
          data_d = data_q | wd_data;
          mask_d = mask_q | wd_data;
        end
        default: begin
        end
      endcase
    end
  end

  // Read mux: sampled every cycle from address, no read strobe.
  always_comb begin
    case (address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: readdata_d = 32'(data_q);
      ADDR_PULSE_LEN:                        readdata_d = 32'(len_q);
      ADDR_PULSE:                            readdata_d = 32'(mask_q);
      default:                               readdata_d = '0;
    endcase
  end

  // Data, mask, length and read registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      mask_q     <= '0;
      len_q      <= LEN_RESET;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      len_q      <= len_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port = data_q;
  assign readdata = readdata_q;

endmodule
